instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PROG_LEN, default 20: number of valid instruction words; legal range 1..1024.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins program execution from pc 0.
REQ-005 SHALL have port pc, output, 10: instruction-memory address.
REQ-006 SHALL have port instruction, input, 23: memory word, read combinationally at pc; fields are [22] write, [21:19] burst, [18] sel, [17:8] addr, [7:0] data.
REQ-007 SHALL have port cmd_valid, output, 1: command to the AHB master is valid.
REQ-008 SHALL have port cmd_ready, input, 1: the AHB master accepts the command.
REQ-009 SHALL have ports cmd_write (1), cmd_burst (3), cmd_sel (1), cmd_addr (10) and cmd_wdata (8), all outputs: command fields for the current beat.
REQ-010 SHALL have port xfer_done, input, 1: one-cycle pulse when the master completes the accepted beat.
REQ-011 SHALL have port rdata, input, 8: read data, valid together with xfer_done.
REQ-012 SHALL have port last_rdata, output, 8: data from the most recent completed read beat.
REQ-013 SHALL have ports busy, done and trunc_err, outputs, 1 each: running; program completed (sticky); burst truncated at program end (sticky).

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT, NEXT and FIN.
REQ-015 IDLE: start=1 SHALL set pc=0, clear done and trunc_err, and go to FETCH; start in any other state SHALL be ignored.
REQ-016 FETCH (1 cycle): SHALL register instruction fields; on the first beat it SHALL latch base address, write, sel and burst, and compute beats as 000/001->1, 010/011->4, 100/101->8, 110/111->16; beat index k=0.
REQ-017 ISSUE: SHALL assert cmd_valid with cmd_addr=(base+k) mod 1024, cmd_wdata=data field of word pc, and cmd_write/cmd_sel/cmd_burst from the first beat; fields SHALL stay stable until cmd_ready; on cmd_valid&cmd_ready it SHALL go to WAIT and drop cmd_valid next cycle.
REQ-018 WAIT: on xfer_done it SHALL go to NEXT, and if cmd_write=0 it SHALL load last_rdata<=rdata in the same edge; xfer_done outside WAIT SHALL be ignored.
REQ-019 NEXT: if pc==PROG_LEN-1 it SHALL go to FIN and set trunc_err if k<beats-1; else pc<=pc+1; if k<beats-1 then k<=k+1 and go to FETCH as a continuation beat (base/ctrl not relatched); else go to FETCH as a new instruction.
REQ-020 FIN: SHALL set done=1 and go to IDLE in 1 cycle; done SHALL hold until the next accepted start or reset.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 A burst of N beats SHALL consume words pc..pc+N-1, and program flow SHALL resume at pc+N.
REQ-023 Minimum latency per beat SHALL be FETCH+ISSUE+WAIT+NEXT = 4 cycles with cmd_ready and xfer_done each asserted one cycle after entry.

Reset
REQ-024 reset SHALL asynchronously force state=IDLE, pc=0, cmd_valid=0, all cmd_* outputs=0, last_rdata=0, busy=0, done=0, trunc_err=0, k=0.
REQ-025 reset mid-transfer SHALL drop cmd_valid immediately; no resumption; a new start SHALL be required.

Verification
REQ-026 Single write: PROG_LEN=1, word0={1,000,0,0x005,0x55}, start, ready/done after 1 cycle -> one command with addr 0x005, wdata 0x55, write=1; done=1 after FIN; pc=0.
REQ-027 Read: word0={0,000,1,0x002,x}, rdata=0xA7 with xfer_done -> cmd_sel=1, cmd_write=0; last_rdata=0xA7; done=1.
REQ-028 Burst 4: word0 burst=011 addr 0x3FE, data fields of words 0..3 = 0x10..0x13 -> addrs 0x3FE, 0x3FF, 0x000, 0x001 with wdata 0x10..0x13; pc then reaches 4.
REQ-029 Truncation: PROG_LEN=2, word0 burst=010 -> 2 beats issued; trunc_err=1, done=1.
REQ-030 Backpressure: cmd_ready held 0 for 5 cycles -> cmd_valid and all cmd_* stable; exactly one command accepted.
REQ-031 Reset in WAIT, then start -> cmd_valid=0 asynchronously; re-execution from pc=0; start pulsed while busy has no effect.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: walks a program of 23-bit words and turns each into one
// or more AHB command beats, handing them to a master over a valid/ready handshake.
module instr_sequencer #(
    parameter int unsigned PROG_LEN = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [9:0]  pc,
    input  logic [22:0] instruction,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [2:0]  cmd_burst,
    output logic        cmd_sel,
    output logic [9:0]  cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic        xfer_done,
    input  logic [7:0]  rdata,
    output logic [7:0]  last_rdata,
    output logic        busy,
    output logic        done,
    output logic        trunc_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;

    localparam logic [9:0] LAST_PC = 10'(PROG_LEN - 1);

    logic [2:0] state_q, state_d;
    logic [9:0] pc_q, pc_d;
    logic [3:0] k_q, k_d;
    logic [3:0] beats_m1_q, beats_m1_d;
    logic [9:0] base_q, base_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       cmd_write_q, cmd_write_d;
    logic [2:0] cmd_burst_q, cmd_burst_d;
    logic       cmd_sel_q, cmd_sel_d;
    logic [9:0] cmd_addr_q, cmd_addr_d;
    logic [7:0] cmd_wdata_q, cmd_wdata_d;
    logic [7:0] last_rdata_q, last_rdata_d;
    logic       done_q, done_d;
    logic       trunc_q, trunc_d;

    // Burst code pairs map to 1/4/8/16 beats; stored as beats-1.
    function automatic logic [3:0] beats_m1_of(input logic [2:0] burst);
        logic [3:0] n;
        case (burst[2:1])
            2'b00:   n = 4'd0;
            2'b01:   n = 4'd3;
            2'b10:   n = 4'd7;
            default: n = 4'd15;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        k_d          = k_q;
        beats_m1_d   = beats_m1_q;
        base_d       = base_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_write_d  = cmd_write_q;
        cmd_burst_d  = cmd_burst_q;
        cmd_sel_d    = cmd_sel_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        last_rdata_d = last_rdata_q;
        done_d       = done_q;
        trunc_d      = trunc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = 10'd0;
                    k_d     = 4'd0;
                    done_d  = 1'b0;
                    trunc_d = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cmd_wdata_d = instruction[7:0];
                // Continuation beats keep the control fields of the burst's first word.
                if (k_q == 4'd0) begin
                    cmd_write_d = instruction[22];
                    cmd_burst_d = instruction[21:19];
                    cmd_sel_d   = instruction[18];
                    base_d      = instruction[17:8];
                    cmd_addr_d  = instruction[17:8];
                    beats_m1_d  = beats_m1_of(instruction[21:19]);
                end else begin
                    cmd_addr_d  = base_q + 10'(k_q);
                end
                cmd_valid_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (xfer_done) begin
                    if (!cmd_write_q) begin
                        last_rdata_d = rdata;
                    end
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (pc_q == LAST_PC) begin
                    if (k_q < beats_m1_q) begin
                        trunc_d = 1'b1;
                    end
                    state_d = FIN;
                end else begin
                    pc_d    = pc_q + 10'd1;
                    k_d     = (k_q < beats_m1_q) ? k_q + 4'd1 : 4'd0;
                    state_d = FETCH;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= 10'd0;
            k_q          <= 4'd0;
            beats_m1_q   <= 4'd0;
            base_q       <= 10'd0;
            cmd_valid_q  <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_burst_q  <= 3'd0;
            cmd_sel_q    <= 1'b0;
            cmd_addr_q   <= 10'd0;
            cmd_wdata_q  <= 8'd0;
            last_rdata_q <= 8'd0;
            done_q       <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            k_q          <= k_d;
            beats_m1_q   <= beats_m1_d;
            base_q       <= base_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_write_q  <= cmd_write_d;
            cmd_burst_q  <= cmd_burst_d;
            cmd_sel_q    <= cmd_sel_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            last_rdata_q <= last_rdata_d;
            done_q       <= done_d;
            trunc_q      <= trunc_d;
        end
    end

    assign pc         = pc_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_write  = cmd_write_q;
    assign cmd_burst  = cmd_burst_q;
    assign cmd_sel    = cmd_sel_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_wdata  = cmd_wdata_q;
    assign last_rdata = last_rdata_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign trunc_err  = trunc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a bus responder answers commands, a monitor
// checks each accepted command against the queued expectation.
module tb_instr_sequencer;

    localparam int unsigned PL = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  pc;
    logic [22:0] instruction;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_burst;
    logic        cmd_sel;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        xfer_done;
    logic [7:0]  rdata;
    logic [7:0]  last_rdata;
    logic        busy;
    logic        done;
    logic        trunc_err;

    logic [22:0] mem [0:1023];
    assign instruction = mem[pc];

    always #5 clk = ~clk;

    instr_sequencer #(.PROG_LEN(PL)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .instruction(instruction),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_burst  (cmd_burst),
        .cmd_sel    (cmd_sel),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .xfer_done  (xfer_done),
        .rdata      (rdata),
        .last_rdata (last_rdata),
        .busy       (busy),
        .done       (done),
        .trunc_err  (trunc_err)
    );

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] wdata;
        logic       write;
        logic       sel;
        logic [2:0] burst;
    } cmd_t;

    cmd_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          hold_cycles = 0;
    bit          stall_done = 1'b0;
    logic [7:0]  rd_val = 8'h00;

    function automatic logic [22:0] word(input logic w, input logic [2:0] b, input logic s,
                                         input logic [9:0] a, input logic [7:0] d);
        return {w, b, s, a, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [7:0] d, input logic w,
                        input logic s, input logic [2:0] b);
        cmd_t c;
        c = '{addr: a, wdata: d, write: w, sel: s, burst: b};
        exp_q.push_back(c);
    endtask

    // Monitor: every accepted command is compared with the oldest expectation.
    always @(negedge clk) begin
        cmd_t e;
        cmd_t a;
        if (!reset && cmd_valid && cmd_ready) begin
            a = {cmd_addr, cmd_wdata, cmd_write, cmd_sel, cmd_burst};
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_cmd: got %0h, expected no command", a);
            end else begin
                e = exp_q.pop_front();
                check("cmd", a, e);
            end
        end
    end

    // Bus responder: optional backpressure, then accept, then complete the beat.
    initial begin
        cmd_t snap;
        cmd_t cur;
        cmd_ready = 1'b0;
        xfer_done = 1'b0;
        rdata     = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!reset && cmd_valid) begin
                snap = {cmd_addr, cmd_wdata, cmd_write, cmd_sel, cmd_burst};
                for (int i = 0; i < hold_cycles; i++) begin
                    @(posedge clk); #1;
                    cur = {cmd_addr, cmd_wdata, cmd_write, cmd_sel, cmd_burst};
                    check("hold_valid", 32'(cmd_valid), 32'd1);
                    check("hold_fields", cur, snap);
                end
                cmd_ready = 1'b1;
                @(posedge clk); #1;
                cmd_ready = 1'b0;
                if (!stall_done) begin
                    xfer_done = 1'b1;
                    rdata     = rd_val;
                    @(posedge clk); #1;
                    xfer_done = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 23'd0;
    endtask

    task automatic load_prog_a();
        clear_mem();
        mem[0] = word(1'b1, 3'b000, 1'b0, 10'h005, 8'h55);
        mem[1] = word(1'b0, 3'b000, 1'b1, 10'h002, 8'h00);
        mem[2] = word(1'b1, 3'b011, 1'b0, 10'h3FE, 8'h10);
        mem[3] = word(1'b0, 3'b000, 1'b1, 10'h123, 8'h11);
        mem[4] = word(1'b0, 3'b110, 1'b0, 10'h0AA, 8'h12);
        mem[5] = word(1'b1, 3'b000, 1'b1, 10'h3FF, 8'h13);
    endtask

    task automatic push_prog_a();
        push(10'h005, 8'h55, 1'b1, 1'b0, 3'b000);
        push(10'h002, 8'h00, 1'b0, 1'b1, 3'b000);
        push(10'h3FE, 8'h10, 1'b1, 1'b0, 3'b011);
        push(10'h3FF, 8'h11, 1'b1, 1'b0, 3'b011);
        push(10'h000, 8'h12, 1'b1, 1'b0, 3'b011);
        push(10'h001, 8'h13, 1'b1, 1'b0, 3'b011);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_fields", {cmd_addr, cmd_wdata, cmd_write, cmd_sel, cmd_burst}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_trunc", 32'(trunc_err), 32'd0);
        check("rst_last_rdata", 32'(last_rdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Program A: single write, single read, 4-beat burst wrapping past 0x3FF.
        load_prog_a();
        rd_val = 8'hA7;
        push_prog_a();
        pulse_start();
        check("a_busy", 32'(busy), 32'd1);
        check("a_done_clear", 32'(done), 32'd0);
        wait_done("a_done");
        check("a_trunc", 32'(trunc_err), 32'd0);
        check("a_last_rdata", 32'(last_rdata), 32'hA7);
        check("a_pc", 32'(pc), 32'd5);
        check("a_busy_end", 32'(busy), 32'd0);
        check("a_queue_empty", 32'(exp_q.size()), 32'd0);

        // Program B: backpressure on every beat, burst cut short by program end.
        clear_mem();
        mem[0] = word(1'b0, 3'b000, 1'b0, 10'h010, 8'h01);
        mem[1] = word(1'b1, 3'b000, 1'b0, 10'h020, 8'h02);
        mem[2] = word(1'b1, 3'b000, 1'b0, 10'h021, 8'h03);
        mem[3] = word(1'b1, 3'b000, 1'b0, 10'h022, 8'h04);
        mem[4] = word(1'b1, 3'b010, 1'b1, 10'h100, 8'h40);
        mem[5] = word(1'b0, 3'b111, 1'b0, 10'h3FF, 8'h41);
        rd_val      = 8'h3C;
        hold_cycles = 5;
        push(10'h010, 8'h01, 1'b0, 1'b0, 3'b000);
        push(10'h020, 8'h02, 1'b1, 1'b0, 3'b000);
        push(10'h021, 8'h03, 1'b1, 1'b0, 3'b000);
        push(10'h022, 8'h04, 1'b1, 1'b0, 3'b000);
        push(10'h100, 8'h40, 1'b1, 1'b1, 3'b010);
        push(10'h101, 8'h41, 1'b1, 1'b1, 3'b010);
        pulse_start();
        check("b_trunc_clear", 32'(trunc_err), 32'd0);
        wait_done("b_done");
        check("b_trunc", 32'(trunc_err), 32'd1);
        check("b_last_rdata", 32'(last_rdata), 32'h3C);
        check("b_pc", 32'(pc), 32'd5);
        check("b_queue_empty", 32'(exp_q.size()), 32'd0);
        hold_cycles = 0;

        // Program C: reset while waiting for completion, then a clean rerun.
        load_prog_a();
        stall_done = 1'b1;
        push(10'h005, 8'h55, 1'b1, 1'b0, 3'b000);
        pulse_start();
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("c_first_accepted", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check("c_waiting_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("c_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("c_rst_busy", 32'(busy), 32'd0);
        check("c_rst_pc", 32'(pc), 32'd0);
        check("c_rst_done", 32'(done), 32'd0);
        check("c_rst_last_rdata", 32'(last_rdata), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        stall_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("c_no_resume", 32'(busy), 32'd0);

        rd_val = 8'h5A;
        push_prog_a();
        pulse_start();
        repeat (8) @(posedge clk);
        #1;
        check("c_busy_before_restart", 32'(busy), 32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("c_done");
        check("c_last_rdata", 32'(last_rdata), 32'h5A);
        check("c_pc", 32'(pc), 32'd5);
        check("c_trunc", 32'(trunc_err), 32'd0);
        check("c_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
